// File: rtl/mem_arbiter_if.sv
// Bundle of the fetch, data and memory-side ports of mem_arbiter.
// Handshake: each *_req is held with stable operands until its *_ready pulse; mem_req is a one-cycle start strobe and mem_valid a one-cycle completion.
interface mem_arbiter_if #(
  parameter int WIDTH = 32
);
  logic             i_req;
  logic [WIDTH-1:0] i_addr;
  logic             i_ready;
  logic [WIDTH-1:0] i_rdata;

  logic             d_req;
  logic             d_we;
  logic [WIDTH-1:0] d_addr;
  logic [WIDTH-1:0] d_wdata;
  logic [2:0]       d_funct3;
  logic             d_ready;
  logic [WIDTH-1:0] d_rdata;

  logic             mem_req;
  logic             mem_we;
  logic [WIDTH-1:0] mem_addr;
  logic [WIDTH-1:0] mem_wdata;
  logic [2:0]       mem_funct3;
  logic             mem_valid;
  logic [WIDTH-1:0] mem_rdata;

  logic             busy;
  logic             err;
  logic [1:0]       dbg_state;

  modport slave (
    input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, d_funct3, mem_valid, mem_rdata,
    output i_ready, i_rdata, d_ready, d_rdata, mem_req, mem_we, mem_addr, mem_wdata,
           mem_funct3, busy, err, dbg_state
  );

  modport master (
    output i_req, i_addr, d_req, d_we, d_addr, d_wdata, d_funct3, mem_valid, mem_rdata,
    input  i_ready, i_rdata, d_ready, d_rdata, mem_req, mem_we, mem_addr, mem_wdata,
           mem_funct3, busy, err, dbg_state
  );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one single-port memory between fetch (I) and data (D) requesters,
// one transaction at a time, with a watchdog that ends hung transactions with err.
module mem_arbiter #(
  parameter int WIDTH   = 32,
  parameter int TIMEOUT = 16
) (
  input  logic          clk,
  input  logic          rst,
  mem_arbiter_if.slave  bus
);

  localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic             last_q, last_d;          // 0 = I granted last, 1 = D
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             mem_req_q, mem_req_d;
  logic             mem_we_q, mem_we_d;
  logic [WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [WIDTH-1:0] mem_wdata_q, mem_wdata_d;
  logic [2:0]       mem_funct3_q, mem_funct3_d;
  logic             i_ready_q, i_ready_d;
  logic             d_ready_q, d_ready_d;
  logic [WIDTH-1:0] i_rdata_q, i_rdata_d;
  logic [WIDTH-1:0] d_rdata_q, d_rdata_d;
  logic             err_q, err_d;

  logic i_elig, d_elig, grant_i, grant_d, timeout_hit;

  // A side in its ready cycle still shows req; masking stops an immediate re-grant.
  assign i_elig      = bus.i_req & ~i_ready_q;
  assign d_elig      = bus.d_req & ~d_ready_q;
  assign grant_d     = d_elig & (~i_elig | ~last_q);
  assign grant_i     = i_elig & ~grant_d;
  assign timeout_hit = (cnt_q == CW'(TIMEOUT - 1));

  always_comb begin
    state_d      = state_q;
    last_d       = last_q;
    cnt_d        = cnt_q;
    mem_req_d    = 1'b0;
    mem_we_d     = mem_we_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    mem_funct3_d = mem_funct3_q;
    i_ready_d    = 1'b0;
    d_ready_d    = 1'b0;
    err_d        = 1'b0;
    i_rdata_d    = i_rdata_q;
    d_rdata_d    = d_rdata_q;
    case (state_q)
      IDLE: begin
        if (grant_d) begin
          state_d      = BUSY_D;
          last_d       = 1'b1;
          mem_req_d    = 1'b1;
          mem_we_d     = bus.d_we;
          mem_addr_d   = bus.d_addr;
          mem_wdata_d  = bus.d_wdata;
          mem_funct3_d = bus.d_funct3;
          cnt_d        = '0;
        end else if (grant_i) begin
          state_d      = BUSY_I;
          last_d       = 1'b0;
          mem_req_d    = 1'b1;
          mem_we_d     = 1'b0;
          mem_addr_d   = bus.i_addr;
          mem_wdata_d  = '0;
          mem_funct3_d = 3'b010;
          cnt_d        = '0;
        end
      end
      BUSY_I: begin
        if (bus.mem_valid) begin
          state_d   = IDLE;
          i_ready_d = 1'b1;
          i_rdata_d = bus.mem_rdata;
        end else if (timeout_hit) begin
          state_d   = IDLE;
          i_ready_d = 1'b1;
          err_d     = 1'b1;
          i_rdata_d = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      BUSY_D: begin
        if (bus.mem_valid) begin
          state_d   = IDLE;
          d_ready_d = 1'b1;
          // A store ack carries no load data, so d_rdata keeps the last load result.
          if (!mem_we_q) d_rdata_d = bus.mem_rdata;
        end else if (timeout_hit) begin
          state_d   = IDLE;
          d_ready_d = 1'b1;
          err_d     = 1'b1;
          d_rdata_d = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      last_q       <= 1'b0;
      cnt_q        <= '0;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      mem_funct3_q <= 3'b000;
      i_ready_q    <= 1'b0;
      d_ready_q    <= 1'b0;
      i_rdata_q    <= '0;
      d_rdata_q    <= '0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_q       <= last_d;
      cnt_q        <= cnt_d;
      mem_req_q    <= mem_req_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      mem_funct3_q <= mem_funct3_d;
      i_ready_q    <= i_ready_d;
      d_ready_q    <= d_ready_d;
      i_rdata_q    <= i_rdata_d;
      d_rdata_q    <= d_rdata_d;
      err_q        <= err_d;
    end
  end

  assign bus.mem_req    = mem_req_q;
  assign bus.mem_we     = mem_we_q;
  assign bus.mem_addr   = mem_addr_q;
  assign bus.mem_wdata  = mem_wdata_q;
  assign bus.mem_funct3 = mem_funct3_q;
  assign bus.i_ready    = i_ready_q;
  assign bus.i_rdata    = i_rdata_q;
  assign bus.d_ready    = d_ready_q;
  assign bus.d_rdata    = d_rdata_q;
  assign bus.err        = err_q;
  assign bus.busy       = (state_q != IDLE);
  assign bus.dbg_state  = state_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus a short random run,
// with a memory responder model and expected-response queues.
module tb_mem_arbiter;
  localparam int W   = 32;
  localparam int TMO = 16;
  localparam int MW  = 2 * W + 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_errors = 0;

  mem_arbiter_if #(.WIDTH(W)) bus ();

  mem_arbiter #(.WIDTH(W), .TIMEOUT(TMO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "simulation time limit");
  end

  // ---------------- scoreboard state ----------------
  logic [W:0]    exp_i_q[$];   // {err, rdata}
  logic [W:0]    exp_d_q[$];
  logic [MW-1:0] exp_mem_q[$]; // {we, funct3, addr, wdata}
  logic [W-1:0]  d_last = '0;

  int   mem_wait = 0;
  logic mem_hang = 1'b0;
  logic stray    = 1'b0;

  task automatic chk(input string tag, input logic [MW-1:0] act, input logic [MW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s act=%h exp=%h", tag, act, exp);
    end
  endtask

  function automatic logic [W-1:0] mem_f(input logic [W-1:0] a);
    if (a == 32'h0000_0100) return 32'h0050_0093;
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0000;
  endfunction

  function automatic logic [MW-1:0] mk_mem(input logic we, input logic [2:0] f3,
                                           input logic [W-1:0] a, input logic [W-1:0] wd);
    return {we, f3, a, wd};
  endfunction

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_busy"},    bus.busy,      0);
    chk({tag, "_iready"},  bus.i_ready,   0);
    chk({tag, "_dready"},  bus.d_ready,   0);
    chk({tag, "_err"},     bus.err,       0);
    chk({tag, "_memreq"},  bus.mem_req,   0);
    chk({tag, "_memflds"}, {bus.mem_we, bus.mem_funct3, bus.mem_addr, bus.mem_wdata}, 0);
    chk({tag, "_irdata"},  bus.i_rdata,   0);
    chk({tag, "_drdata"},  bus.d_rdata,   0);
    chk({tag, "_state"},   bus.dbg_state, 0);
  endtask

  // ---------------- memory responder ----------------
  int   wcnt = 0;
  logic pend = 1'b0;
  initial begin
    bus.mem_valid = 1'b0;
    bus.mem_rdata = '0;
    forever begin
      @(negedge clk);
      bus.mem_valid = stray;
      if (stray) bus.mem_rdata = $urandom;
      if (!rst) pend = 1'b0;
      else if (bus.mem_req) begin
        pend = 1'b1;
        wcnt = mem_wait;
      end else if (pend && wcnt > 0) wcnt--;
      if (pend && !mem_hang && wcnt == 0) begin
        bus.mem_valid = 1'b1;
        // store acks return distinct data so a wrongly captured ack is visible
        bus.mem_rdata = bus.mem_we ? ~mem_f(bus.mem_addr) : mem_f(bus.mem_addr);
        pend = 1'b0;
      end
    end
  end

  // ---------------- monitor ----------------
  initial begin
    logic [MW-1:0] em;
    logic [W:0]    er;
    forever begin
      @(negedge clk);
      if (rst) begin
        if (bus.mem_req) begin
          if (exp_mem_q.size() == 0) chk("mem_req_unexpected", 1, 0);
          else begin
            em = exp_mem_q.pop_front();
            chk("mem_fields", {bus.mem_we, bus.mem_funct3, bus.mem_addr, bus.mem_wdata}, em);
          end
        end
        if (bus.i_ready) begin
          if (exp_i_q.size() == 0) chk("i_ready_unexpected", 1, 0);
          else begin
            er = exp_i_q.pop_front();
            chk("i_resp", {bus.err, bus.i_rdata}, er);
          end
        end
        if (bus.d_ready) begin
          if (exp_d_q.size() == 0) chk("d_ready_unexpected", 1, 0);
          else begin
            er = exp_d_q.pop_front();
            chk("d_resp", {bus.err, bus.d_rdata}, er);
          end
        end
        if (bus.err && !bus.i_ready && !bus.d_ready) chk("err_without_ready", 1, 0);
      end
    end
  end

  // ---------------- drivers ----------------
  // Called at a negedge; holds req through the ready cycle, drops it one cycle later.
  task automatic i_issue(input logic [W-1:0] addr, output int lat);
    int t0, n;
    bus.i_req  = 1'b1;
    bus.i_addr = addr;
    exp_i_q.push_back(mem_hang ? {1'b1, {W{1'b0}}} : {1'b0, mem_f(addr)});
    t0 = cyc;
    n  = 0;
    do begin @(negedge clk); n++; end while (!bus.i_ready && n < 200);
    if (!bus.i_ready) chk("i_ready_wait", bus.i_ready, 1);
    lat = cyc - t0;
    @(negedge clk);
    bus.i_req = 1'b0;
  endtask

  task automatic d_issue(input logic we, input logic [W-1:0] addr, input logic [W-1:0] wd,
                         input logic [2:0] f3, output int lat);
    int t0, n;
    bus.d_req    = 1'b1;
    bus.d_we     = we;
    bus.d_addr   = addr;
    bus.d_wdata  = wd;
    bus.d_funct3 = f3;
    if (mem_hang) d_last = '0;
    else if (!we) d_last = mem_f(addr);
    exp_d_q.push_back({mem_hang, d_last});
    t0 = cyc;
    n  = 0;
    do begin @(negedge clk); n++; end while (!bus.d_ready && n < 200);
    if (!bus.d_ready) chk("d_ready_wait", bus.d_ready, 1);
    lat = cyc - t0;
    @(negedge clk);
    bus.d_req = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int lat, lat_d1, lat_d2, lat_i1, lat_i2, n;
    logic [W-1:0] a, wd;
    logic we;
    logic [2:0] f3;
    bus.i_req = 1'b0; bus.i_addr = '0;
    bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_addr = '0; bus.d_wdata = '0; bus.d_funct3 = '0;

    repeat (3) @(negedge clk);
    chk_reset_outputs("reset");
    rst = 1'b1;
    @(negedge clk);

    // contention straight out of reset: D, I, D, I
    mem_wait = 0;
    exp_mem_q.push_back(mk_mem(1'b0, 3'b100, 32'h0000_1000, 32'h1111_1111));
    exp_mem_q.push_back(mk_mem(1'b0, 3'b010, 32'h0000_0200, '0));
    exp_mem_q.push_back(mk_mem(1'b1, 3'b001, 32'h0000_1004, 32'h2222_2222));
    exp_mem_q.push_back(mk_mem(1'b0, 3'b010, 32'h0000_0204, '0));
    fork
      begin
        d_issue(1'b0, 32'h0000_1000, 32'h1111_1111, 3'b100, lat_d1);
        d_issue(1'b1, 32'h0000_1004, 32'h2222_2222, 3'b001, lat_d2);
      end
      begin
        i_issue(32'h0000_0200, lat_i1);
        i_issue(32'h0000_0204, lat_i2);
      end
    join
    chk("cont_lat_d1", lat_d1, 2);
    chk("cont_lat_i1", lat_i1, 4);
    chk("cont_lat_d2", lat_d2, 3);
    chk("cont_lat_i2", lat_i2, 3);

    // single I read
    exp_mem_q.push_back(mk_mem(1'b0, 3'b010, 32'h0000_0100, '0));
    i_issue(32'h0000_0100, lat);
    chk("iread_lat", lat, 2);

    // D load then D store with 3 wait cycles
    mem_wait = 1;
    exp_mem_q.push_back(mk_mem(1'b0, 3'b010, 32'h0000_2000, 32'h0));
    d_issue(1'b0, 32'h0000_2000, 32'h0, 3'b010, lat);
    chk("dload_lat", lat, 3);
    mem_wait = 3;
    exp_mem_q.push_back(mk_mem(1'b1, 3'b010, 32'h0000_2000, 32'hDEAD_BEEF));
    d_issue(1'b1, 32'h0000_2000, 32'hDEAD_BEEF, 3'b010, lat);
    chk("dstore_lat", lat, 5);

    // stray mem_valid while idle
    @(posedge clk); stray = 1'b1;
    @(posedge clk); stray = 1'b0;
    repeat (2) begin
      @(negedge clk);
      chk("stray_ready", {bus.i_ready, bus.d_ready, bus.err}, 0);
      chk("stray_busy",  bus.busy, 0);
      chk("stray_state", bus.dbg_state, 0);
    end

    // short random run
    for (int k = 0; k < 8; k++) begin
      mem_wait = $urandom_range(0, 4);
      a  = {$urandom_range(0, 32'hFFFF), 2'b00};
      wd = $urandom;
      if ($urandom_range(0, 1) == 1) begin
        we = ($urandom_range(0, 1) == 1);
        f3 = 3'($urandom_range(0, 7));
        exp_mem_q.push_back(mk_mem(we, f3, a, wd));
        d_issue(we, a, wd, f3, lat);
      end else begin
        exp_mem_q.push_back(mk_mem(1'b0, 3'b010, a, '0));
        i_issue(a, lat);
      end
      chk("rand_lat", lat, 2 + mem_wait);
    end

    // watchdog timeout on a D load, then normal traffic
    mem_hang = 1'b1;
    exp_mem_q.push_back(mk_mem(1'b0, 3'b010, 32'h0000_3000, 32'h0));
    d_issue(1'b0, 32'h0000_3000, 32'h0, 3'b010, lat);
    chk("tmo_lat", lat, TMO + 1);
    mem_hang = 1'b0;
    mem_wait = 0;
    exp_mem_q.push_back(mk_mem(1'b0, 3'b010, 32'h0000_3004, 32'h0));
    d_issue(1'b0, 32'h0000_3004, 32'h0, 3'b010, lat);
    chk("post_tmo_lat", lat, 2);
    exp_mem_q.push_back(mk_mem(1'b0, 3'b010, 32'h0000_0100, '0));
    i_issue(32'h0000_0100, lat);
    chk("post_tmo_ilat", lat, 2);

    // reset in the middle of an I transaction
    mem_hang   = 1'b1;
    bus.i_req  = 1'b1;
    bus.i_addr = 32'h0000_0400;
    exp_mem_q.push_back(mk_mem(1'b0, 3'b010, 32'h0000_0400, '0));
    n = 0;
    do begin @(negedge clk); n++; end while (!bus.busy && n < 10);
    chk("rst_busy_before", bus.busy, 1);
    @(negedge clk);
    #2 rst = 1'b0;
    #1 chk_reset_outputs("midrst");
    d_last = '0;
    repeat (3) begin
      @(negedge clk);
      chk("midrst_no_iready", bus.i_ready, 0);
    end
    mem_hang = 1'b0;
    exp_i_q.push_back({1'b0, mem_f(32'h0000_0400)});
    exp_mem_q.push_back(mk_mem(1'b0, 3'b010, 32'h0000_0400, '0));
    rst = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!bus.i_ready && n < 50);
    chk("postrst_lat", n, 2);
    @(negedge clk);
    bus.i_req = 1'b0;

    repeat (4) @(negedge clk);
    chk("left_i",   exp_i_q.size(),   0);
    chk("left_d",   exp_d_q.size(),   0);
    chk("left_mem", exp_mem_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
